// File: rtl/imem_boot_ctrl.sv
// Boot loader for instruction memory: streams words into IMEM over valid/ready,
// holds the core in reset while loading, then releases it after a settle delay.
module imem_boot_ctrl #(
   parameter int unsigned IMEM_WORDS  = 256,
   parameter int unsigned RELEASE_DLY = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_start_in,
   input  logic [31:0] load_len_in,
   input  logic        wr_valid_in,
   input  logic [31:0] wr_data_in,
   output logic        wr_ready_out,
   output logic        imem_we_out,
   output logic [31:0] imem_addr_out,
   output logic [31:0] imem_data_out,
   output logic        core_reset_n_out,
   output logic        busy_out,
   output logic        done_out,
   output logic        err_out
);

   // state | meaning
   // IDLE  | no program loaded, core held in reset
   // LOAD  | accepting stream words, one write per accepted word
   // DRAIN | last write done, counting down the release delay
   // RUN   | program loaded, core released
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

   localparam logic [31:0] MAX_LEN  = 32'(IMEM_WORDS);
   localparam logic [3:0]  DLY_INIT = 4'(RELEASE_DLY - 1);

   state_t      state, state_nx;
   logic [31:0] len_q, len_nx;
   logic [31:0] cnt_q, cnt_nx;
   logic [31:0] addr_q, addr_nx;
   logic [31:0] data_q, data_nx;
   logic [3:0]  dly_q, dly_nx;
   logic        we_q, we_nx;
   logic        err_q, err_nx;
   logic        len_legal;

   assign len_legal = (load_len_in <= MAX_LEN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         len_q  <= '0;
         cnt_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         dly_q  <= '0;
         we_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         len_q  <= len_nx;
         cnt_q  <= cnt_nx;
         addr_q <= addr_nx;
         data_q <= data_nx;
         dly_q  <= dly_nx;
         we_q   <= we_nx;
         err_q  <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      len_nx   = len_q;
      cnt_nx   = cnt_q;
      addr_nx  = addr_q;
      data_nx  = data_q;
      dly_nx   = dly_q;
      we_nx    = 1'b0;
      err_nx   = err_q;
      case (state)
         IDLE, RUN: begin
            // An illegal request leaves the current state alone, so a running core keeps running.
            if (load_start_in) begin
               if (!len_legal) begin
                  err_nx = 1'b1;
               end else begin
                  err_nx = 1'b0;
                  len_nx = load_len_in;
                  cnt_nx = '0;
                  if (load_len_in == 32'd0) begin
                     state_nx = DRAIN;
                     dly_nx   = DLY_INIT;
                  end else begin
                     state_nx = LOAD;
                  end
               end
            end
         end
         LOAD: begin
            if (wr_valid_in) begin
               we_nx   = 1'b1;
               addr_nx = cnt_q;
               data_nx = wr_data_in;
               cnt_nx  = cnt_q + 32'd1;
               if (cnt_q == len_q - 32'd1) begin
                  state_nx = DRAIN;
                  dly_nx   = DLY_INIT;
               end
            end
         end
         DRAIN: begin
            if (dly_q == 4'd0) state_nx = RUN;
            else               dly_nx   = dly_q - 4'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign wr_ready_out     = (state == LOAD);
   assign imem_we_out      = we_q;
   assign imem_addr_out    = addr_q;
   assign imem_data_out    = data_q;
   assign core_reset_n_out = (state == RUN);
   assign busy_out         = (state == LOAD) || (state == DRAIN);
   assign done_out         = (state == RUN);
   assign err_out          = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: randomized loads compared against a
// word-list reference of expected writes and release timing.
module tb_imem_boot_ctrl;
   localparam int IMEM_WORDS  = 256;
   localparam int RELEASE_DLY = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        load_start_in = 1'b0;
   logic [31:0] load_len_in = '0;
   logic        wr_valid_in = 1'b0;
   logic [31:0] wr_data_in = '0;
   logic        wr_ready_out, imem_we_out, core_reset_n_out, busy_out, done_out, err_out;
   logic [31:0] imem_addr_out, imem_data_out;

   int vectors = 0;
   int errors  = 0;
   bit in_run  = 1'b0;
   logic [31:0] words [0:IMEM_WORDS-1];

   // {ready, we, core_reset_n, busy, done, err}
   wire [5:0] stat = {wr_ready_out, imem_we_out, core_reset_n_out, busy_out, done_out, err_out};

   imem_boot_ctrl #(.IMEM_WORDS(IMEM_WORDS), .RELEASE_DLY(RELEASE_DLY)) dut (
      .clk(clk), .reset_n(reset_n),
      .load_start_in(load_start_in), .load_len_in(load_len_in),
      .wr_valid_in(wr_valid_in), .wr_data_in(wr_data_in), .wr_ready_out(wr_ready_out),
      .imem_we_out(imem_we_out), .imem_addr_out(imem_addr_out), .imem_data_out(imem_data_out),
      .core_reset_n_out(core_reset_n_out), .busy_out(busy_out), .done_out(done_out),
      .err_out(err_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic fill_random();
      for (int i = 0; i < IMEM_WORDS; i++) words[i] = $urandom;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0; load_start_in = 1'b0; wr_valid_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      in_run = 1'b0;
   endtask

   // Issues a load of len words and checks every cycle until release (or the error response).
   // mode 0: valid held high, 1: valid alternates 1,0,1,..., 2: random valid plus stray starts.
   task automatic run_load(input logic [31:0] len, input int mode);
      int   k, cyc;
      logic v;
      logic [5:0] exp;
      @(negedge clk);
      load_start_in = 1'b1; load_len_in = len; wr_valid_in = 1'b0;
      @(negedge clk);
      load_start_in = 1'b0;
      if (len > 32'(IMEM_WORDS)) begin
         exp = {1'b0, 1'b0, in_run, 1'b0, in_run, 1'b1};
         vectors++;
         if (stat !== exp) begin
            errors++;
            $display("FAIL illegal_start len=%0d: stat=%b want %b", len, stat, exp);
         end
         return;
      end
      in_run = 1'b0;
      exp = (len == 0) ? 6'b000100 : 6'b100100;
      vectors++;
      if (stat !== exp) begin
         errors++;
         $display("FAIL start len=%0d: stat=%b want %b", len, stat, exp);
      end
      k = 0; cyc = 0;
      while (k < int'(len)) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         wr_valid_in = v;
         wr_data_in  = v ? words[k] : $urandom;
         if (mode == 2) begin
            load_start_in = ($urandom_range(0, 3) == 0);
            load_len_in   = $urandom_range(0, 300);
         end
         @(negedge clk);
         load_start_in = 1'b0;
         if (v) begin
            vectors++;
            if ({imem_addr_out, imem_data_out} !== {32'(k), words[k]}) begin
               errors++;
               $display("FAIL write k=%0d: addr=%0d data=%h want addr=%0d data=%h",
                        k, imem_addr_out, imem_data_out, k, words[k]);
            end
            k++;
         end
         exp = {(k < int'(len)), v, 1'b0, 1'b1, 1'b0, 1'b0};
         vectors++;
         if (stat !== exp) begin
            errors++;
            $display("FAIL load_cycle len=%0d cyc=%0d: stat=%b want %b", len, cyc, stat, exp);
         end
         cyc++;
      end
      wr_valid_in = 1'b0;
      for (int j = 1; j < RELEASE_DLY; j++) begin
         @(negedge clk);
         vectors++;
         if (stat !== 6'b000100) begin
            errors++;
            $display("FAIL drain len=%0d j=%0d: stat=%b want 000100", len, j, stat);
         end
      end
      @(negedge clk);
      vectors++;
      if (stat !== 6'b001010) begin
         errors++;
         $display("FAIL release len=%0d: stat=%b want 001010", len, stat);
      end
      in_run = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if ({stat, imem_addr_out, imem_data_out} !== 70'd0) begin
         errors++;
         $display("FAIL reset: stat=%b addr=%h data=%h want all zero", stat, imem_addr_out, imem_data_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_idle_valid();
      wr_valid_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_data_in = $urandom;
         @(negedge clk);
         vectors++;
         if (stat !== 6'b000000) begin
            errors++;
            $display("FAIL idle_valid i=%0d: stat=%b want 000000", i, stat);
         end
      end
      wr_valid_in = 1'b0;
   endtask

   task automatic test_illegal_idle();
      run_load(32'(IMEM_WORDS + 1), 0);
      fill_random();
      run_load(32'd1, 0);
   endtask

   task automatic test_basic();
      apply_reset();
      words[0] = 32'h00500093; words[1] = 32'h00A00113;
      words[2] = 32'h002081B3; words[3] = 32'h0000006F;
      run_load(32'd4, 0);
   endtask

   task automatic test_gaps();
      fill_random();
      run_load(32'd3, 1);
   endtask

   task automatic test_illegal_run();
      run_load(32'(IMEM_WORDS + 1), 0);
      run_load(32'hFFFF_FFFF, 0);
      fill_random();
      run_load(32'd2, 0);
   endtask

   task automatic test_zero_len();
      run_load(32'd0, 0);
   endtask

   task automatic test_max_len();
      fill_random();
      run_load(32'(IMEM_WORDS), 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         fill_random();
         run_load($urandom_range(1, 24), 2);
      end
   endtask

   task automatic test_reset_midload();
      fill_random();
      @(negedge clk);
      load_start_in = 1'b1; load_len_in = 32'd5;
      @(negedge clk);
      load_start_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wr_valid_in = 1'b1; wr_data_in = words[i];
         @(negedge clk);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if ({stat, imem_addr_out, imem_data_out} !== 70'd0) begin
         errors++;
         $display("FAIL reset_midload: stat=%b addr=%h data=%h want all zero", stat, imem_addr_out, imem_data_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
      in_run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (stat !== 6'b000000) begin
            errors++;
            $display("FAIL post_reset i=%0d: stat=%b want 000000", i, stat);
         end
      end
      wr_valid_in = 1'b0;
      run_load(32'd2, 0);
   endtask

   initial begin
      test_reset();
      test_idle_valid();
      test_illegal_idle();
      test_basic();
      test_gaps();
      test_illegal_run();
      test_zero_len();
      test_max_len();
      test_random();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/program-load controller for the instruction fetch stage. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory through its write port. While loading it holds the pipeline in reset. Once the programmed word count is written and a fixed settle delay has elapsed, it releases the pipeline so fetch starts at PC 0.

## Interface
- IMEM_WORDS, 256: instruction memory depth in words; legal load lengths are 0..IMEM_WORDS.
- RELEASE_DLY, 4: cycles between the last write and core reset release; legal range 1..15.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset for all state.
- load_start_in  in  1  single-cycle request to begin a load; samples load_len_in.
- load_len_in  in  32  number of words to load, unsigned.
- wr_valid_in  in  1  stream word valid.
- wr_data_in  in  32  stream instruction word.
- wr_ready_out  out  1  controller accepts a word this cycle.
- imem_we_out  out  1  instruction memory write enable.
- imem_addr_out  out  32  word address; byte address = imem_addr_out << 2.
- imem_data_out  out  32  instruction word to write.
- core_reset_n_out  out  1  active-low reset to the PC and IF/ID pipeline.
- busy_out  out  1  high in LOAD or DRAIN.
- done_out  out  1  high in RUN.
- err_out  out  1  sticky; set by an illegal length, cleared by the next legal load_start_in.

## Operation
- States: IDLE, LOAD, DRAIN, RUN.
- All outputs are registered or decoded from registered state only.
- Reset values of all outputs:
  - state = IDLE.
  - wr_ready_out = 0, imem_we_out = 0, imem_addr_out = 0, imem_data_out = 0.
  - core_reset_n_out = 0, busy_out = 0, done_out = 0, err_out = 0.
  - Word counter = 0, delay counter = 0.
- IDLE on load_start_in:
  - load_len_in > IMEM_WORDS: err_out <= 1, stay IDLE.
  - load_len_in == 0: latch length, clear err_out, go to DRAIN.
  - Otherwise: latch length, clear counter and err_out, go to LOAD.
- LOAD:
  - wr_ready_out = 1.
  - A word is accepted on an edge where wr_valid_in & wr_ready_out.
  - On acceptance: imem_we_out <= 1, imem_addr_out <= counter, imem_data_out <= wr_data_in, counter <= counter + 1.
  - With no acceptance, imem_we_out <= 0.
  - When the accepted word is the last one (counter == len−1), go to DRAIN.
- DRAIN:
  - wr_ready_out = 0.
  - imem_we_out drops on the first DRAIN edge.
  - Delay counter counts RELEASE_DLY edges, then go to RUN.
- RUN:
  - core_reset_n_out = 1, done_out = 1.
  - load_start_in with a legal length returns to LOAD, or to DRAIN if the length is 0. core_reset_n_out falls on that same edge.
  - load_start_in with an illegal length sets err_out; the controller stays in RUN and the core keeps running.
- load_start_in while in LOAD or DRAIN is ignored.
- Address arithmetic is a 32-bit unsigned counter. It never exceeds IMEM_WORDS−1 because length is checked at start, so no wrap occurs.
- wr_valid_in outside LOAD has no effect and no word is consumed.

## Timing
- Word write latency: accepted at edge N, so imem_we_out/addr/data are valid during cycle N+1. Instruction memory commits the write at edge N+1.
- Throughput: 1 word per cycle with wr_valid_in held high.
- Load of L words: wr_ready_out is high for exactly L accepting edges. State is RUN at edge (last accept) + RELEASE_DLY. core_reset_n_out goes high in the same cycle as done_out.
- Reset mid-load: everything returns to reset values asynchronously, core_reset_n_out = 0. Partially written memory contents are left as-is, and a new load_start_in is required.
- load_start_in in RUN: core_reset_n_out low from the next cycle and wr_ready_out high from the next cycle; the pipeline is flushed via its own reset.

## Test plan
- Reset, then load_start_in with len=4 and words 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F, valid held high:
  - 4 writes to addresses 0..3 with matching data.
  - core_reset_n_out rises RELEASE_DLY edges after the 4th accept.
- len=3 with wr_valid_in toggling 1,0,1,0,1:
  - Exactly 3 writes at addresses 0,1,2; imem_we_out low in the gap cycles.
  - No duplicate or skipped address.
- len=IMEM_WORDS+1: err_out=1, state IDLE, wr_ready_out=0, core_reset_n_out=0.
  - A following len=1 load clears err_out and completes.
- len=0: no writes; done_out=1 and core_reset_n_out=1 after RELEASE_DLY edges.
- In RUN, load_start_in with len=2: core_reset_n_out falls next cycle, 2 writes occur at addresses 0,1, then release.
- Assert reset_n low after 2 of 5 words:
  - All outputs return to reset values immediately.
  - After reset release, wr_ready_out stays 0 until a new load_start_in.
